// File: rtl/pkt_tx_pkg.sv
// Shared constants and FSM state type for the 0xAA-framed telemetry packet path.
// The receiver imports the same header constant so both ends agree on framing.
package pkt_tx_pkg;

  localparam int unsigned PAYLOAD_BYTES_DEF = 5;
  localparam logic [7:0]  HEADER_BYTE_DEF   = 8'hAA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CSUM = 2'd3
  } pkt_tx_state_e;

endpackage

// File: rtl/packet_tx_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the requester
// that did not own the last grant wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = 1'b0;
    case (req_i)
      2'b10:   idx_o = 1'b1;
      2'b11:   idx_o = ~last_i;
      default: idx_o = 1'b0;
    endcase
    gnt_o = 2'b00;
    if (|req_i) gnt_o = idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/packet_tx_arbiter.sv
// Round-robin framer for two telemetry requesters onto one UART byte channel:
// header, payload MSB-first, optional XOR checksum (macro PKT_TX_CHECKSUM_EN).
// Byte handshake: a byte transfers on a clock edge where tx_valid && tx_ready;
// tx_valid/tx_data hold until then and tx_ready is ignored while tx_valid=0.
module packet_tx_arbiter
  import pkt_tx_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0,
  input  logic [8*PAYLOAD_BYTES-1:0] data0,
  output logic                       ack0,
  input  logic                       req1,
  input  logic [8*PAYLOAD_BYTES-1:0] data1,
  output logic                       ack1,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic                       grant_id,
  output logic                       frame_done,
  output logic [1:0]                 state_dbg
);

  localparam int W  = 8 * PAYLOAD_BYTES;
  localparam int CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

  pkt_tx_state_e state_q;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  shift_d;
  logic [CW-1:0] cnt_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          ack0_q, ack1_q;
  logic          busy_q;
  logic          grant_q;
  logic          done_q;
  logic [1:0]    gnt;
  logic          win;
  logic          accept;
`ifdef PKT_TX_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  rr_arb2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (grant_q),
    .gnt_o  (gnt),
    .idx_o  (win)
  );

  assign accept  = tx_valid_q & tx_ready;
  assign shift_d = shift_q << 8;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef PKT_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Data is sampled only here, on the grant edge.
          if (|gnt) begin
            state_q    <= HDR;
            shift_q    <= win ? data1 : data0;
            grant_q    <= win;
            ack0_q     <= gnt[0];
            ack1_q     <= gnt[1];
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER_BYTE;
            cnt_q      <= '0;
`ifdef PKT_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
          end
        end
        HDR: begin
          if (accept) begin
            state_q   <= PAY;
            cnt_q     <= '0;
            tx_data_q <= shift_q[W-1 -: 8];
          end
        end
        PAY: begin
          if (accept) begin
`ifdef PKT_TX_CHECKSUM_EN
            csum_q <= csum_q ^ tx_data_q;
`endif
            if (cnt_q == LAST_IDX) begin
`ifdef PKT_TX_CHECKSUM_EN
              state_q   <= CSUM;
              tx_data_q <= csum_q ^ tx_data_q;
`else
              state_q    <= IDLE;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              shift_q   <= shift_d;
              tx_data_q <= shift_d[W-1 -: 8];
              cnt_q     <= cnt_q + CW'(1);
            end
          end
        end
`ifdef PKT_TX_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Bench for packet_tx_arbiter: directed scenarios plus random requests and
// backpressure, checked every cycle against a frame-queue reference model.
module tb_packet_tx_arbiter;
  import pkt_tx_pkg::*;

  localparam int PB = PAYLOAD_BYTES_DEF;
  localparam int W  = 8 * PB;
`ifdef PKT_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, req0, req1, tx_ready;
  logic [W-1:0] data0, data1;
  logic         ack0, ack1, tx_valid, busy, grant_id, frame_done;
  logic [7:0]   tx_data;
  logic [1:0]   state_dbg;

  packet_tx_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .data1      (data1),
    .ack1       (ack1),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / checker ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of bytes still to be sent.
  bit         m_busy;
  bit         m_last = 1'b1;
  bit         m_ack0, m_ack1, m_done;
  bit         m_data_zero;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         done_cnt;
  int         ack1_cnt;

  task automatic model_edge();
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_busy      = 1'b0;
      m_last      = 1'b1;
      m_data_zero = 1'b1;
      exp_q.delete();
    end else if (!m_busy) begin
      if (req0 || req1) begin
        bit           w;
        logic [W-1:0] d;
        logic [7:0]   x;
        logic [7:0]   b;
        w = (req0 && req1) ? !m_last : req1;
        m_last = w;
        d = w ? data1 : data0;
        exp_q.delete();
        exp_q.push_back(HEADER_BYTE_DEF);
        x = 8'h00;
        for (int i = 0; i < PB; i++) begin
          b = d[W-1-8*i -: 8];
          exp_q.push_back(b);
          x = x ^ b;
        end
        if (CSUM_EN) exp_q.push_back(x);
        m_busy      = 1'b1;
        m_data_zero = 1'b0;
        if (w) m_ack1 = 1'b1;
        else   m_ack0 = 1'b1;
      end
    end else if (tx_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // ---------------- driver: one clock cycle with full output check ----------------
  task automatic cycle();
    @(posedge clk);
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    model_edge();
    @(negedge clk);
    check_eq("tx_valid",   tx_valid,   m_busy);
    check_eq("busy",       busy,       m_busy);
    check_eq("grant_id",   grant_id,   m_last);
    check_eq("ack0",       ack0,       m_ack0);
    check_eq("ack1",       ack1,       m_ack1);
    check_eq("frame_done", frame_done, m_done);
    check_eq("state_idle", state_dbg == IDLE, !m_busy);
    if (m_busy)           check_eq("tx_data", tx_data, exp_q[0]);
    else if (m_data_zero) check_eq("tx_data_rst", tx_data, 8'h00);
    if (frame_done) done_cnt++;
    if (ack1) ack1_cnt++;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] x;
    int         waited;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tx_ready = 1'b0;
    data0 = '0; data1 = '0;
    done_cnt = 0; ack1_cnt = 0;

    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single request with counting-byte payload (0x0102030405 for 5 bytes).
    for (int i = 0; i < PB; i++) data0[W-1-8*i -: 8] = 8'(i + 1);
    got_q.delete();
    done_cnt = 0;
    tx_ready = 1'b1;
    req0 = 1'b1;
    cycle();
    req0 = 1'b0;
    data0 = rand_data();
    repeat (PB + 4) cycle();
    check_eq("single_len", got_q.size(), PB + 1 + int'(CSUM_EN));
    if (got_q.size() == PB + 1 + int'(CSUM_EN)) begin
      check_eq("single_hdr", got_q[0], 8'hAA);
      x = 8'h00;
      for (int i = 0; i < PB; i++) begin
        check_eq("single_pay", got_q[i+1], 8'(i + 1));
        x = x ^ 8'(i + 1);
      end
      if (CSUM_EN) check_eq("single_csum", got_q[PB+1], x);
    end
    check_eq("single_done_cnt", done_cnt, 1);
    check_eq("single_grant", grant_id, 1'b0);

    // Contention from reset: frames must alternate 0,1,0,1.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 8 * (PB + 3); c++) begin
      data0 = rand_data();
      data1 = rand_data();
      cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (PB + 4) cycle();

    // Withdrawn request: req1 pulsed for one cycle during a req0 frame.
    req0 = 1'b1;
    waited = 0;
    cycle();
    while (!ack0 && waited < 20) begin
      cycle();
      waited++;
    end
    check_eq("withdraw_ack0_seen", ack0, 1'b1);
    req0 = 1'b0;
    ack1_cnt = 0;
    cycle();
    req1 = 1'b1;
    cycle();
    req1 = 1'b0;
    repeat (PB + 5) cycle();
    check_eq("withdraw_no_ack1", ack1_cnt, 0);

    // Reset while payload byte 2 is on the channel.
    tx_ready = 1'b1;
    req0 = 1'b1;
    cycle();
    req0 = 1'b0;
    repeat (3) cycle();
    check_eq("rst_mid_on_pay2", tx_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
    done_cnt = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_grant", grant_id, 1'b1);
    req1 = 1'b1;
    data1 = rand_data();
    cycle();
    req1 = 1'b0;
    repeat (PB + 4) cycle();
    check_eq("rst_mid_done_cnt", done_cnt, 1);
    check_eq("rst_mid_grant_after", grant_id, 1'b1);

    // Random requests, data and backpressure.
    for (int c = 0; c < 1500; c++) begin
      req0     = ($urandom_range(0, 3) != 0);
      req1     = ($urandom_range(0, 2) != 0);
      tx_ready = $urandom_range(0, 1);
      data0    = rand_data();
      data1    = rand_data();
      cycle();
    end
    req0 = 1'b0; req1 = 1'b0; tx_ready = 1'b1;
    repeat (PB + 4) cycle();
    check_eq("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_tx_arbiter.md
# packet_tx_arbiter

Frames and schedules outbound telemetry packets onto a single shared UART transmit byte channel. Two requesters compete for the channel: the motion/status channel and the lidar echo channel. The block arbitrates round-robin, latches the winner's payload, and emits header 0xAA, the payload bytes MSB-first, and an optional checksum byte over a valid/ready byte handshake. It is the transmit-side counterpart of the 0xAA-framed packet receiver and feeds the uart_tx instance.

## Interface
- PAYLOAD_BYTES, 5, payload bytes per frame (range 1–8).
- HEADER_BYTE, 8'hAA, first byte of every frame.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 (status) wants a frame sent.
- data0  in  8*PAYLOAD_BYTES  requester 0 payload; byte 0 is bits [8*PAYLOAD_BYTES-1 -: 8].
- ack0  out  1  one-cycle pulse when requester 0's payload is latched.
- req1, data1, ack1: same as above, for requester 1 (lidar).
- tx_valid  out  1  tx_data holds a byte for the transmitter.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- busy  out  1  a frame is in progress (any state except IDLE).
- grant_id  out  1  requester owning the current/last frame.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.

## Operation
- States: IDLE, HDR, PAY, CSUM.
- IDLE:
  - If req0 || req1, select a winner.
  - Latch the winner's data into the shift register.
  - Set grant_id, pulse ack of the winner, go to HDR.
- Arbitration is round-robin and sampled only in IDLE.
  - Only one requester active: that requester wins.
  - Both active: the requester that is not grant_id wins.
  - grant_id resets to 1, so requester 0 wins the first tie.
- HDR:
  - tx_valid=1, tx_data=HEADER_BYTE.
  - On acceptance, go to PAY with byte counter = 0.
- PAY:
  - tx_data = top byte of the shift register.
  - On acceptance, shift left by 8 and increment the counter.
  - On accepting byte PAYLOAD_BYTES-1, go to CSUM if the checksum is enabled, else go to IDLE.
- CSUM:
  - tx_data = XOR of all latched payload bytes.
  - On acceptance, go to IDLE.
- Every transition into IDLE from a frame pulses frame_done.
- tx_valid stays high and tx_data stays stable until accepted. tx_ready while tx_valid=0 is ignored.
- A requester may drop req or change data from the cycle after its ack. Data changes before ack are unconstrained; the block samples data only on the grant edge.
- A req withdrawn before being granted is never acked.
- A req held high after ack requests another frame, which is arbitrated on the next IDLE cycle.
- Reset values:
  - state = IDLE, grant_id = 1.
  - tx_valid, ack0, ack1, busy, frame_done = 0.
  - tx_data = 8'h00, counter = 0.
- Reset mid-frame aborts the frame. The next cycle is IDLE with no frame_done and no further acks.

## Timing
- Grant: req seen high in IDLE at edge N. ack and busy are high and tx_valid=1 with the header during cycle N+1.
- With tx_ready held high, each byte occupies one cycle. The frame takes PAYLOAD_BYTES+1 cycles, or +2 with the checksum.
- frame_done is high the cycle after the last acceptance; state is IDLE in that cycle.
- Minimum inter-frame gap: one cycle with tx_valid=0, because IDLE always lasts at least one cycle.
- All outputs are registered. There is no combinational path from tx_ready or req to any output.

## Configuration
- PKT_TX_CHECKSUM_EN defined: CSUM state present; frames are PAYLOAD_BYTES+2 bytes.
- PKT_TX_CHECKSUM_EN undefined: CSUM state and XOR accumulator removed; PAY goes directly to IDLE; frames are PAYLOAD_BYTES+1 bytes.

## Structure
- Shared package pkt_tx_pkg holds:
  - the state enum (IDLE, HDR, PAY, CSUM);
  - the default HEADER_BYTE constant 8'hAA;
  - the default PAYLOAD_BYTES constant 5.
- The receiver reuses the same header constant.
- One sub-module: rr_arb2, a two-way round-robin arbiter.
  - Inputs: req[1:0], last grant.
  - Outputs: one-hot grant, winner index.
  - Purely combinational, instantiated once.
- The FSM, shift register, counter and checksum accumulator stay in packet_tx_arbiter.

## Test plan
- Single request, tx_ready=1: req0 with data0=0x0102030405 → ack0 in cycle 1; tx bytes AA,01,02,03,04,05,01 (checksum enabled, 7 cycles); frame_done once; grant_id=0.
- Contention: req0 and req1 held high from reset → frames alternate 0,1,0,1; each ack matches grant_id; at least one tx_valid=0 cycle between frames.
- Backpressure: tx_ready toggled randomly → tx_data stable while tx_valid && !tx_ready; byte order AA,payload,checksum preserved; no byte duplicated or lost.
- Withdrawn request: req1 pulsed high for one cycle while a req0 frame is in progress → no ack1; the next frame comes only from req0 (if still requesting).
- Reset mid-frame: rst asserted during PAY byte 2 → next cycle tx_valid=0, busy=0, grant_id=1, no frame_done; a subsequent req1 produces a complete frame.
- Checksum disabled build: data0=0x0102030405 → bytes AA,01,02,03,04,05; frame_done the cycle after byte 05 is accepted.
